reg_bus_arbiter: RTL
====================

// Module: reg_bus_arbiter
// PURPOSE
// - Shares the 8-bit register-bank bus between two masters: m0 = uart_if, m1 = i2c_if.
// - Each master issues single-cycle access strobes with no backpressure, so each master
//   has a 1-deep pending slot that captures its strobe.
// - Round-robin arbitration picks which slot goes next; one bank access runs at a time.
// - Read data and a completion pulse are returned to the master that issued the access.
// - Sits between the host interfaces and the register bank in the top level.
// PARAMETERS
// - ADDR_W      default 8  register address width
// - DATA_W      default 8  register data width
// - RD_LATENCY  default 1  bank cycles from the reg_en strobe to valid reg_rdata (1..15)
// PORTS
// - clk            in   1       system clock
// - reset          in   1       synchronous reset, active high
// - mN_reg_en      in   1       access strobe (N=0,1), one cycle per access
// - mN_write_en    in   1       1 = write, 0 = read; qualified by mN_reg_en
// - mN_addr        in   ADDR_W  access address, sampled with mN_reg_en
// - mN_wdata       in   DATA_W  write data, sampled with mN_reg_en
// - mN_lock        in   1       hold the grant across accesses (used only with REG_ARB_LOCK_EN)
// - mN_rdata       out  DATA_W  read data, held until that master's next read completes
// - mN_done        out  1       one-cycle pulse when mN's access completes
// - mN_busy        out  1       mN's pending slot is occupied
// - mN_ovf         out  1       sticky: a strobe from mN was dropped
// - reg_addr       out  ADDR_W  bank address
// - reg_wdata      out  DATA_W  bank write data
// - reg_en         out  1       bank access strobe
// - reg_we         out  1       bank write strobe
// - reg_rdata      in   DATA_W  bank read data
// - grant_mon      out  2       {active, granted master index}
// BEHAVIOUR
// - Reset: every output is 0. FSM goes to IDLE, both slots are emptied, rr_last=1
//   (so m0 wins first). Reset mid-access abandons the access with no done pulse.
// - Capture: mN_reg_en=1 with the slot empty loads {we,addr,wdata}; busy=1 from the next cycle.
// - Same-cycle reload: a strobe in the cycle the slot clears (DONE for mN) is accepted.
// - Overflow: a strobe while the slot is full and not clearing is dropped; mN_ovf=1 until reset.
// - FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
// - IDLE:
//   - If any slot is full, grant it. When both are full, grant !rr_last.
//   - A slot loaded in cycle t can be granted in cycle t+1 at the earliest.
// - ISSUE (exactly 1 cycle):
//   - Drive reg_addr/reg_wdata from the slot; reg_en=1; reg_we=slot.we.
//   - reg_addr/reg_wdata hold their last value outside ISSUE.
//   - Load the wait counter with RD_LATENCY-1.
// - WAIT: count down to 0 (RD_LATENCY cycles in total after ISSUE, including this state).
// - DONE (1 cycle):
//   - For a read, mN_rdata <= reg_rdata.
//   - mN_done=1 for this one cycle; clear the slot; rr_last <= N.
// - Timing:
//   - Strobe to done on an idle bus = RD_LATENCY+3 cycles.
//   - Back-to-back throughput = one access per RD_LATENCY+3 cycles.
// - Writes also produce mN_done; mN_rdata is unchanged by a write.
// - Both strobes in the same cycle: both are captured; order follows rr_last.
// CONFIGURATION
// - Macro: REG_ARB_LOCK_EN.
// - Defined:
//   - In IDLE, if the previous grant went to mN, mN_lock=1 and mN's slot fills, mN is
//     re-granted ahead of round-robin.
//   - While mN_lock=1 and mN's slot is empty, the other master's slot is not granted.
//   - Dropping mN_lock restores round-robin the next cycle.
//   - This keeps block reads/writes atomic.
// - Not defined: mN_lock is ignored and arbitration is pure round-robin.
// TESTING
// - m0 write addr=0x10 data=0xA5 -> reg_en=reg_we=1 for 1 cycle, reg_addr=0x10,
//   reg_wdata=0xA5; m0_done 4 cycles after the strobe (RD_LATENCY=1).
// - m1 read addr=0x22 with the bank returning 0x3C -> m1_rdata=0x3C and m1_done=1 together;
//   m0_done stays 0.
// - m0 and m1 strobe in the same cycle after reset -> m0 is served first, then m1;
//   a second pair of strobes -> m1 first.
// - m0 strobes twice, 2 cycles apart, while its first access is pending -> second strobe
//   dropped, m0_ovf=1 and stays 1; one m0_done pulse only.
// - reset asserted during WAIT -> no mN_done; all outputs 0 the next cycle; both slots empty.
// - REG_ARB_LOCK_EN, m0_lock=1, m0 issues 3 reads while m1 is pending -> all 3 m0 reads
//   complete before m1; without the macro the accesses alternate m0, m1, m0, m0.

Source files
------------

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: shares the register-bank bus between uart_if (m0) and i2c_if (m1) with round-robin
// arbitration over 1-deep pending slots. Optional macro REG_ARB_LOCK_EN enables mN_lock grant holding.
module reg_bus_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_reg_en,
  input  logic              m0_write_en,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_done,
  output logic              m0_busy,
  output logic              m0_ovf,
  input  logic              m1_reg_en,
  input  logic              m1_write_en,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_done,
  output logic              m1_busy,
  output logic              m1_ovf,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_en,
  output logic              reg_we,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [1:0]        grant_mon
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } slot_t;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              rr_last_q, rr_last_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        full_q, full_d;
  logic [1:0]        ovf_q, ovf_d;
  logic [1:0]        en, clr;
  slot_t             req    [2];
  slot_t             slot_q [2];
  slot_t             slot_d [2];
  logic [DATA_W-1:0] rdata_q [2];
  logic [DATA_W-1:0] rdata_d [2];
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic              pick, pick_valid;

  assign en     = {m1_reg_en, m0_reg_en};
  assign req[0] = {m0_write_en, m0_addr, m0_wdata};
  assign req[1] = {m1_write_en, m1_addr, m1_wdata};

  // Arbitration over registered slot state, so a slot loaded this cycle competes next cycle.
  always_comb begin
    pick_valid = |full_q;
    if (&full_q)        pick = ~rr_last_q;
    else if (full_q[0]) pick = 1'b0;
    else                pick = 1'b1;
`ifdef REG_ARB_LOCK_EN
    if ((rr_last_q ? m1_lock : m0_lock)) begin
      pick       = rr_last_q;
      pick_valid = full_q[rr_last_q];
    end
`endif
  end

`ifndef REG_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = m0_lock ^ m1_lock;
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_last_d   = rr_last_q;
    cnt_d       = cnt_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    case (state_q)
      IDLE: if (pick_valid) begin
        gnt_d       = pick;
        reg_addr_d  = slot_q[pick].addr;
        reg_wdata_d = slot_q[pick].wdata;
        state_d     = ISSUE;
      end
      ISSUE: begin
        cnt_d   = 4'(RD_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DONE: begin
        rr_last_d = gnt_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      clr[n]     = (state_q == DONE) && (gnt_q == n[0]);
      full_d[n]  = full_q[n] & ~clr[n];
      slot_d[n]  = slot_q[n];
      ovf_d[n]   = ovf_q[n] | (en[n] & full_q[n] & ~clr[n]);
      rdata_d[n] = rdata_q[n];
      if (en[n] && (!full_q[n] || clr[n])) begin
        full_d[n] = 1'b1;
        slot_d[n] = req[n];
      end
      // Last WAIT cycle holds valid bank data; capturing here presents it together with done.
      if (state_q == WAIT && cnt_q == 4'd0 && gnt_q == n[0] && !slot_q[n].we)
        rdata_d[n] = reg_rdata;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      rr_last_q   <= 1'b1;
      cnt_q       <= '0;
      full_q      <= '0;
      ovf_q       <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      rdata_q[0]  <= '0;
      rdata_q[1]  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_last_q   <= rr_last_d;
      cnt_q       <= cnt_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      rdata_q[0]  <= rdata_d[0];
      rdata_q[1]  <= rdata_d[1];
    end
  end

  // NOTE: slot payload is not reset; it is only ever read while its full bit is set.
  always_ff @(posedge clk) begin
    slot_q[0] <= slot_d[0];
    slot_q[1] <= slot_d[1];
  end

  assign reg_en    = (state_q == ISSUE);
  assign reg_we    = reg_en & slot_q[gnt_q].we;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign m0_done   = (state_q == DONE) && !gnt_q;
  assign m1_done   = (state_q == DONE) && gnt_q;
  assign m0_busy   = full_q[0];
  assign m1_busy   = full_q[1];
  assign m0_ovf    = ovf_q[0];
  assign m1_ovf    = ovf_q[1];
  assign m0_rdata  = rdata_q[0];
  assign m1_rdata  = rdata_q[1];
  assign grant_mon = (state_q == IDLE) ? 2'b00 : {1'b1, gnt_q};

endmodule
